agu_pass_scheduler: RTL

Sequences the AGU address-generation pipeline across the passes of one NTT. Per pass it launches the pipeline, counts BN/MA index beats, waits for the done indication, then drains for a fixed gap before the next pass. It sits between the top-level NTT controller (start/done handshake) and the AGU pipeline (enable in; index-valid and done out). A watchdog and a beat-count check flag faults.

---
 rtl/agu_pass_scheduler.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/agu_pass_scheduler.sv
// Pass sequencer for the AGU address-generation pipeline: launches, counts
// BN/MA beats, checks the per-pass beat total and drains between passes.
module agu_pass_scheduler #(
  parameter int unsigned PASS_W    = 4,
  parameter int unsigned BEAT_W    = 16,
  parameter int unsigned DRAIN_CYC = 4,
  parameter int unsigned TO_CYC    = 1023
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [PASS_W-1:0] num_pass,
  input  logic [BEAT_W-1:0] beats_per_pass,
  output logic              AGU_enable,
  input  logic              BN_MA_out_en,
  input  logic              AGU_done_out,
  output logic [PASS_W-1:0] pass_idx,
  output logic [BEAT_W-1:0] beat_cnt,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code
);

  localparam int unsigned WD_W = $clog2(TO_CYC + 1);
  localparam int unsigned DR_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LAUNCH = 3'd1;
  localparam logic [2:0] S_RUN    = 3'd2;
  localparam logic [2:0] S_DRAIN  = 3'd3;
  localparam logic [2:0] S_FIN    = 3'd4;
  localparam logic [2:0] S_ERR    = 3'd5;

  localparam logic [1:0] E_NONE    = 2'd0;
  localparam logic [1:0] E_ZERO    = 2'd1;
  localparam logic [1:0] E_BEATS   = 2'd2;
  localparam logic [1:0] E_TIMEOUT = 2'd3;

  localparam logic [BEAT_W-1:0] BEAT_MAX = '1;

  logic [2:0]        state_q, state_d;
  logic [PASS_W-1:0] npass_q, npass_d;
  logic [BEAT_W-1:0] bpp_q, bpp_d;
  logic [PASS_W-1:0] pass_q, pass_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic [DR_W-1:0]   dr_q, dr_d;
  logic [1:0]        code_q, code_d;
  logic              agu_en_q, agu_en_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [BEAT_W-1:0] beat_run;

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      npass_q  <= '0;
      bpp_q    <= '0;
      pass_q   <= '0;
      beat_q   <= '0;
      wd_q     <= '0;
      dr_q     <= '0;
      code_q   <= E_NONE;
      agu_en_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      npass_q  <= npass_d;
      bpp_q    <= bpp_d;
      pass_q   <= pass_d;
      beat_q   <= beat_d;
      wd_q     <= wd_d;
      dr_q     <= dr_d;
      code_q   <= code_d;
      agu_en_q <= agu_en_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  // Next-state logic; registered outputs are decoded from the next state.
  always_comb begin
    state_d  = state_q;
    npass_d  = npass_q;
    bpp_d    = bpp_q;
    pass_d   = pass_q;
    beat_d   = beat_q;
    wd_d     = wd_q;
    dr_d     = dr_q;
    code_d   = code_q;
    beat_run = beat_q;
    if (BN_MA_out_en && (beat_q != BEAT_MAX)) begin
      beat_run = beat_q + BEAT_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (num_pass == '0) begin
            state_d = S_ERR;
            code_d  = E_ZERO;
          end else begin
            state_d = S_LAUNCH;
            npass_d = num_pass;
            bpp_d   = beats_per_pass;
            pass_d  = '0;
            beat_d  = '0;
            code_d  = E_NONE;
          end
        end
      end
      S_LAUNCH: begin
        beat_d  = '0;
        wd_d    = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        // A beat in the done cycle is counted before the total is compared.
        beat_d = beat_run;
        wd_d   = BN_MA_out_en ? '0 : wd_q + WD_W'(1);
        if (AGU_done_out) begin
          dr_d = '0;
          if (beat_run == bpp_q) begin
            state_d = S_DRAIN;
          end else begin
            state_d = S_ERR;
            code_d  = E_BEATS;
          end
        end else if (!BN_MA_out_en && (wd_q == WD_W'(TO_CYC - 1))) begin
          state_d = S_ERR;
          code_d  = E_TIMEOUT;
        end
      end
      S_DRAIN: begin
        if (dr_q == DR_W'(DRAIN_CYC - 1)) begin
          if (pass_q == (npass_q - PASS_W'(1))) begin
            state_d = S_FIN;
          end else begin
            pass_d  = pass_q + PASS_W'(1);
            state_d = S_LAUNCH;
          end
        end else begin
          dr_d = dr_q + DR_W'(1);
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      S_ERR: begin
        if (start) begin
          state_d = S_IDLE;
          code_d  = E_NONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort wins over everything, including a same-cycle done.
    if (abort && (state_q != S_IDLE) && (state_q != S_ERR)) begin
      state_d = S_ERR;
      code_d  = E_TIMEOUT;
    end

    agu_en_d = (state_d == S_LAUNCH) || (state_d == S_RUN);
    busy_d   = (state_d != S_IDLE);
    done_d   = (state_d == S_FIN);
    err_d    = (state_d == S_ERR);
  end

  assign AGU_enable = agu_en_q;
  assign pass_idx   = pass_q;
  assign beat_cnt   = beat_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign err_code   = code_q;

endmodule
